bus_mcast_arbiter: RTL and testbench

Parametrised successor to the single-transaction bus generator/arbiter. It sits between `drvrs` source FIFOs and the same `drvrs` sink FIFOs. It serves one packet at a time, chosen by fair round-robin, and routes the packet by the destination ID held in its header. New behaviour over the previous generation: per-sink backpressure, broadcast delivery split over several cycles, and counting of dropped (mis-addressed) packets.

---
 rtl/bus_mcast_arbiter.sv | 145 ++++++++++++++
 tb/tb_bus_mcast_arbiter.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/bus_mcast_arbiter.sv
// Round-robin packet arbiter between source and sink FIFOs with
// ID-based unicast/broadcast routing, per-sink backpressure and drop counting.
module bus_mcast_arbiter #(
   parameter int                pckg_sz   = 32,
   parameter int                drvrs     = 4,
   parameter int                id_w      = 8,
   parameter logic [id_w-1:0]   broadcast = 8'hFF
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [drvrs-1:0]           pndng,
   input  logic [drvrs*pckg_sz-1:0]   D_pop,
   output logic [drvrs-1:0]           pop,
   output logic [drvrs-1:0]           push,
   output logic [drvrs*pckg_sz-1:0]   D_push,
   input  logic [drvrs-1:0]           full,
   output logic [15:0]                drop_cnt,
   output logic                       busy
);

   localparam int GW = (drvrs > 1) ? $clog2(drvrs) : 1;
   localparam logic [drvrs-1:0] ONE = {{(drvrs-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      S_IDLE,
      S_POP,
      S_ROUTE,
      S_DELIVER
   } state_t;

   state_t               r_state;
   state_t               w_next;
   logic [GW-1:0]        r_g;
   logic [GW-1:0]        r_last_g;
   logic [GW-1:0]        w_grant;
   logic                 w_grant_vld;
   logic [pckg_sz-1:0]   r_pkt;
   logic [pckg_sz-1:0]   w_head;
   logic [drvrs-1:0]     r_mask;
   logic [drvrs-1:0]     w_g_oh;
   logic [drvrs-1:0]     w_uc_mask;
   logic [drvrs-1:0]     w_left;
   logic [id_w-1:0]      w_dst;
   logic                 w_is_bc;
   logic                 w_is_uc;
   logic [15:0]          r_drop;

   // Search upward from the port after the last grant, wrapping once.
   always_comb begin
      int idx;
      idx         = 0;
      w_grant     = '0;
      w_grant_vld = 1'b0;
      for (int i = 0; i < drvrs; i++) begin
         idx = int'(r_last_g) + 1 + i;
         if (idx >= drvrs)
            idx = idx - drvrs;
         if (!w_grant_vld && pndng[idx]) begin
            w_grant_vld = 1'b1;
            w_grant     = GW'(idx);
         end
      end
   end

   assign w_head    = D_pop[int'(r_g)*pckg_sz +: pckg_sz];
   assign w_dst     = r_pkt[pckg_sz-1 -: id_w];
   assign w_g_oh    = ONE << r_g;
   assign w_uc_mask = ONE << w_dst;
   assign w_is_bc   = (w_dst == broadcast);
   assign w_is_uc   = (32'(w_dst) < 32'(drvrs)) &&
                      (32'(w_dst) != 32'(r_g));
   assign w_left    = r_mask & full;

   always_ff @(posedge clk) begin
      if (!reset)
         r_state <= S_IDLE;
      else
         r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_IDLE:
            if (|pndng)
               w_next = S_POP;
         S_POP:
            w_next = pndng[r_g] ? S_ROUTE : S_IDLE;
         S_ROUTE:
            w_next = (w_is_bc || w_is_uc) ? S_DELIVER : S_IDLE;
         S_DELIVER:
            if (w_left == '0)
               w_next = S_IDLE;
         default:
            w_next = S_IDLE;
      endcase
   end

   always_comb begin
      pop  = '0;
      push = '0;
      busy = (r_state != S_IDLE);
      unique case (r_state)
         S_POP:     pop  = pndng & w_g_oh;
         S_DELIVER: push = r_mask & ~full;
         default: ;
      endcase
   end

   // A sink that was full keeps its mask bit and is retried next cycle.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_last_g <= GW'(drvrs - 1);
         r_g      <= '0;
         r_pkt    <= '0;
         r_mask   <= '0;
         r_drop   <= '0;
      end else begin
         unique case (r_state)
            S_IDLE:
               if (w_grant_vld) begin
                  r_g      <= w_grant;
                  r_last_g <= w_grant;
               end
            S_POP:
               if (pndng[r_g])
                  r_pkt <= w_head;
            S_ROUTE:
               if (w_is_bc)
                  r_mask <= ~w_g_oh;
               else if (w_is_uc)
                  r_mask <= w_uc_mask;
               else if (r_drop != 16'hFFFF)
                  r_drop <= r_drop + 16'd1;
            S_DELIVER:
               r_mask <= w_left;
            default: ;
         endcase
      end
   end

   assign D_push   = {drvrs{r_pkt}};
   assign drop_cnt = r_drop;

endmodule

// File: tb/tb_bus_mcast_arbiter.sv
// Directed self-checking bench for bus_mcast_arbiter (4 ports, 32-bit
// packets): reset, fairness, unicast, broadcast backpressure, drops, reset.
module tb_bus_mcast_arbiter;

   logic          clk = 1'b0;
   logic          reset;
   logic [3:0]    pndng;
   logic [127:0]  D_pop;
   logic [3:0]    pop;
   logic [3:0]    push;
   logic [127:0]  D_push;
   logic [3:0]    full;
   logic [15:0]   drop_cnt;
   logic          busy;

   int errors = 0;
   int checks = 0;

   bus_mcast_arbiter dut (
      .clk      (clk),
      .reset    (reset),
      .pndng    (pndng),
      .D_pop    (D_pop),
      .pop      (pop),
      .push     (push),
      .D_push   (D_push),
      .full     (full),
      .drop_cnt (drop_cnt),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   initial begin
      logic [3:0] ep;
      logic [3:0] eq;
      reset = 1'b0;
      pndng = 4'hF;
      full  = 4'h0;
      // src3->0, src2->3, src1->2, src0->1
      D_pop = {32'h0000_3303, 32'h0300_3302,
               32'h0200_3301, 32'h0100_3300};

      repeat (3) begin
         cyc();
         smp();
         chk("rst_pop", 32'(pop), 32'h0);
         chk("rst_push", 32'(push), 32'h0);
         chk("rst_dpush", {31'b0, |D_push}, 32'h0);
         chk("rst_drop", 32'(drop_cnt), 32'h0);
         chk("rst_busy", 32'(busy), 32'h0);
      end

      cyc();
      reset = 1'b1;
      smp();
      chk("fair_idle0", 32'(busy), 32'h0);
      for (int n = 1; n < 24; n++) begin
         cyc();
         smp();
         ep = 4'h0;
         eq = 4'h0;
         if (n % 4 == 1)
            ep = 4'b0001 << (((n - 1) / 4) % 4);
         if (n % 4 == 3)
            eq = 4'b0001 << ((((n - 3) / 4) + 1) % 4);
         chk($sformatf("fair_pop%0d", n), 32'(pop), 32'(ep));
         chk($sformatf("fair_push%0d", n), 32'(push), 32'(eq));
         if (n == 3)
            chk("fair_data", D_push[63:32], 32'h0100_3300);
      end
      cyc();
      pndng = 4'h0;
      smp();
      chk("fair_end_busy", 32'(busy), 32'h0);

      cyc();
      pndng = 4'b0010;
      D_pop[63:32] = 32'h0200_00AB;
      smp();
      chk("uc_idle_pop", 32'(pop), 32'h0);
      cyc();
      smp();
      chk("uc_pop", 32'(pop), 32'h2);
      cyc();
      pndng = 4'h0;
      smp();
      chk("uc_route_pop", 32'(pop), 32'h0);
      chk("uc_route_push", 32'(push), 32'h0);
      chk("uc_route_busy", 32'(busy), 32'h1);
      chk("uc_dpush", D_push[95:64], 32'h0200_00AB);
      cyc();
      smp();
      chk("uc_push", 32'(push), 32'h4);
      cyc();
      smp();
      chk("uc_after_push", 32'(push), 32'h0);
      chk("uc_after_busy", 32'(busy), 32'h0);

      cyc();
      pndng = 4'b0001;
      D_pop[31:0] = 32'hFF00_1234;
      full = 4'b0100;
      smp();
      chk("bc_idle_busy", 32'(busy), 32'h0);
      cyc();
      smp();
      chk("bc_pop", 32'(pop), 32'h1);
      cyc();
      pndng = 4'h0;
      smp();
      chk("bc_route_push", 32'(push), 32'h0);
      cyc();
      smp();
      chk("bc_push1", 32'(push), 32'hA);
      chk("bc_data", D_push[127:96], 32'hFF00_1234);
      cyc();
      smp();
      chk("bc_hold1", 32'(push), 32'h0);
      chk("bc_hold_busy", 32'(busy), 32'h1);
      cyc();
      smp();
      chk("bc_hold2", 32'(push), 32'h0);
      cyc();
      full = 4'h0;
      smp();
      chk("bc_push2", 32'(push), 32'h4);
      cyc();
      smp();
      chk("bc_done_push", 32'(push), 32'h0);
      chk("bc_done_busy", 32'(busy), 32'h0);

      cyc();
      pndng = 4'b1000;
      D_pop[127:96] = 32'h0700_0000;
      smp();
      cyc();
      smp();
      chk("drop1_pop", 32'(pop), 32'h8);
      cyc();
      pndng = 4'h0;
      smp();
      chk("drop1_route_busy", 32'(busy), 32'h1);
      cyc();
      smp();
      chk("drop1_busy", 32'(busy), 32'h0);
      chk("drop1_push", 32'(push), 32'h0);
      chk("drop1_cnt", 32'(drop_cnt), 32'h1);
      cyc();
      pndng = 4'b0100;
      D_pop[95:64] = 32'h0200_0055;
      smp();
      cyc();
      smp();
      chk("drop2_pop", 32'(pop), 32'h4);
      cyc();
      pndng = 4'h0;
      smp();
      chk("drop2_route_busy", 32'(busy), 32'h1);
      cyc();
      smp();
      chk("drop2_busy", 32'(busy), 32'h0);
      chk("drop2_push", 32'(push), 32'h0);
      chk("drop2_cnt", 32'(drop_cnt), 32'h2);

      cyc();
      pndng = 4'b0001;
      D_pop[31:0] = 32'hFF00_5678;
      full = 4'hF;
      smp();
      cyc();
      smp();
      chk("rbc_pop", 32'(pop), 32'h1);
      cyc();
      pndng = 4'h0;
      smp();
      cyc();
      smp();
      chk("rbc_deliver_push", 32'(push), 32'h0);
      chk("rbc_deliver_busy", 32'(busy), 32'h1);
      cyc();
      reset = 1'b0;
      smp();
      chk("rbc_rst_push", 32'(push), 32'h0);
      cyc();
      reset = 1'b1;
      pndng = 4'hF;
      full  = 4'h0;
      smp();
      chk("rbc_busy", 32'(busy), 32'h0);
      chk("rbc_push", 32'(push), 32'h0);
      chk("rbc_drop", 32'(drop_cnt), 32'h0);
      chk("rbc_dpush", {31'b0, |D_push}, 32'h0);
      cyc();
      smp();
      chk("rbc_next_grant", 32'(pop), 32'h1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
